hazard_ctrl: RTL
================

# hazard_ctrl

Decode-stage pipeline controller for the 5-stage RV32I core. Classifies the instruction in IF/ID, tracks destination registers of in-flight instructions in EX/MEM/WB, and sequences the pipeline. It generates load-use stalls, redirect flushes, global freeze on data-memory stall, and registered forwarding selects for the EX operand muxes. It also keeps saturating stall/flush event counters for performance debug.

## Interface
- CNT_W, 32, width of each event counter
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous reset, active-high
- inst  in  32  instruction held in IF/ID
- id_valid  in  1  IF/ID holds a real instruction (0 = bubble)
- ex_redirect  in  1  branch taken / jal / jalr resolved in EX this cycle
- mem_stall  in  1  data memory not ready; freeze whole pipeline
- pc_en  out  1  PC register update enable
- if_id_en  out  1  IF/ID register load enable
- if_id_flush  out  1  clear IF/ID to bubble
- id_ex_bubble  out  1  load bubble into ID/EX instead of decoded instruction
- fwd_a_sel  out  2  EX rs1 source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
- fwd_b_sel  out  2  EX rs2 source, same encoding
- ctrl_state  out  2  action taken last cycle: 00 RUN, 01 STALL, 10 FLUSH, 11 FREEZE
- stall_cnt  out  CNT_W  load-use stall cycles, saturating
- flush_cnt  out  CNT_W  redirect events, saturating

## Operation
- Opcode class from inst[6:2]: LOAD 00000, OP-IMM 00100, STORE 01000, BRANCH 11000, JALR 11001, AUIPC 00101, LUI 01101, OP 01100, JAL 11011; other opcodes use nothing and write nothing.
- uses_rs1: LOAD, OP-IMM, STORE, BRANCH, JALR, OP. uses_rs2: STORE, BRANCH, OP.
- writes_rd: LOAD, OP-IMM, JALR, AUIPC, LUI, OP, JAL, and only when rd = inst[11:7] != 0.
- Shadow slots ex_s, mem_s, wb_s hold {valid, rd, is_load}. They shift each non-frozen cycle: wb_s<=mem_s, mem_s<=ex_s, ex_s<=issued instruction or bubble.
- Match: rsN == slot.rd, slot.valid, use flag set, rsN != 0.
- Load-use hazard: id_valid and a match against ex_s with ex_s.is_load.
- Priority per cycle: FREEZE (mem_stall) > FLUSH (ex_redirect) > STALL (load-use) > RUN.
- RUN: pc_en=1, if_id_en=1, if_id_flush=0, id_ex_bubble=!id_valid; ex_s<=decoded instruction.
- STALL: pc_en=0, if_id_en=0, id_ex_bubble=1; ex_s<=bubble; stall_cnt+1.
- FLUSH: pc_en=1 (redirect target), if_id_flush=1, id_ex_bubble=1; ex_s<=bubble; flush_cnt+1. A pending load-use hazard is discarded.
- FREEZE: pc_en=0, if_id_en=0, if_id_flush=0, id_ex_bubble=0; slots, fwd selects and counters hold. ex_redirect is ignored; its source holds it until unfrozen.
- Forwarding selects are registered on issue (RUN only): 01 on a match with the current ex_s, else 10 on a match with mem_s, else 00. The WB case is covered by regfile write-first. On STALL/FLUSH they are loaded with 00.
- Counters saturate at all-ones; no wrap.

## Timing
- pc_en, if_id_en, if_id_flush, id_ex_bubble: combinational from inputs and slot registers, same cycle.
- fwd_a_sel/fwd_b_sel valid in the cycle the instruction occupies EX (one edge after issue).
- ctrl_state and counters update on the edge ending the action cycle.
- Load-use stall lasts exactly one cycle; the consumer then issues with fwd=10.
- Reset (asynchronous, any time): slots invalid, fwd selects 00, ctrl_state 00, counters 0. While rst is high: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_bubble=1.
- First edge after release: normal RUN evaluation.

## Structure
- Shared package core_pkg: opcode class constants, slot struct {valid, rd[4:0], is_load}, fwd_sel and ctrl_state encodings.
- Sub-module inst_class_dec: combinational inst -> {uses_rs1, uses_rs2, writes_rd, is_load, rs1, rs2, rd}. Reused by the regfile read stage.
- Top hazard_ctrl: slot shift register, priority logic, fwd registers, counters.

## Test plan
- lw x5,0(x1) then add x6,x5,x2 -> one STALL cycle (pc_en=0, id_ex_bubble=1, stall_cnt=1); add then issues and has fwd_a_sel=10, fwd_b_sel=00.
- addi x5,x0,3 then sub x7,x5,x5 -> no stall; sub in EX has fwd_a_sel=fwd_b_sel=01. With one nop between -> both 10.
- addi x0,x0,1 then add x3,x0,x0 -> no stall, fwd selects 00.
- Load-use hazard and ex_redirect in the same cycle -> FLUSH only (if_id_flush=1, flush_cnt=1, stall_cnt=0).
- mem_stall high 3 cycles while a load-use pair is in EX/ID -> all enables 0 and counters held; stall occurs on the first unfrozen cycle.
- CNT_W=4, 20 consecutive load-use pairs -> stall_cnt saturates at 15. Assert rst mid-sequence -> all outputs take reset values immediately, before the next edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared decode/hazard types for the 5-stage RV32I core.
package core_pkg;

  localparam logic [4:0] OpcLoad   = 5'b00000;
  localparam logic [4:0] OpcOpImm  = 5'b00100;
  localparam logic [4:0] OpcStore  = 5'b01000;
  localparam logic [4:0] OpcBranch = 5'b11000;
  localparam logic [4:0] OpcJalr   = 5'b11001;
  localparam logic [4:0] OpcAuipc  = 5'b00101;
  localparam logic [4:0] OpcLui    = 5'b01101;
  localparam logic [4:0] OpcOp     = 5'b01100;
  localparam logic [4:0] OpcJal    = 5'b11011;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } slot_t;

  typedef enum logic [1:0] {
    FwdRf    = 2'b00,
    FwdExMem = 2'b01,
    FwdMemWb = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StStall  = 2'b01,
    StFlush  = 2'b10,
    StFreeze = 2'b11
  } ctrl_state_e;

  // Source register rs is produced by the instruction tracked in slot s.
  function automatic logic slot_hit(slot_t s, logic [4:0] rs, logic use_rs);
    return use_rs && s.valid && (rs != 5'd0) && (s.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      inst;
  logic             id_valid;
  logic             ex_redirect;
  logic             mem_stall;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output inst, id_valid, ex_redirect, mem_stall,
    input  pc_en, if_id_en, if_id_flush, id_ex_bubble, fwd_a_sel, fwd_b_sel,
    input  ctrl_state, stall_cnt, flush_cnt
  );

  modport slave (
    input  inst, id_valid, ex_redirect, mem_stall,
    output pc_en, if_id_en, if_id_flush, id_ex_bubble, fwd_a_sel, fwd_b_sel,
    output ctrl_state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/inst_class_dec.sv
// Classifies an RV32I instruction by register usage; shared with the regfile read stage.
module inst_class_dec
  import core_pkg::*;
(
  input  logic [31:0] inst,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        writes_rd,
  output logic        is_load,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd
);

  logic wr_class;
  logic ld_class;
  logic unused_inst;

  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];
  assign rd  = inst[11:7];
  assign unused_inst = ^{inst[31:25], inst[14:12], inst[1:0]};

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    wr_class = 1'b0;
    ld_class = 1'b0;
    case (inst[6:2])
      OpcLoad:   begin uses_rs1 = 1'b1; wr_class = 1'b1; ld_class = 1'b1; end
      OpcOpImm:  begin uses_rs1 = 1'b1; wr_class = 1'b1; end
      OpcStore:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OpcBranch: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OpcJalr:   begin uses_rs1 = 1'b1; wr_class = 1'b1; end
      OpcAuipc:  wr_class = 1'b1;
      OpcLui:    wr_class = 1'b1;
      OpcJal:    wr_class = 1'b1;
      OpcOp:     begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; wr_class = 1'b1; end
      default:   ;
    endcase
  end

  // A write to x0 is architecturally a no-op, so it never creates a hazard.
  assign writes_rd = wr_class && (rd != 5'd0);
  assign is_load   = ld_class && writes_rd;

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: stall/flush/freeze sequencing, forwarding selects,
// and saturating event counters.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  hazard_ctrl_if.slave bus
);

  logic       uses_rs1, uses_rs2, writes_rd, is_load;
  logic [4:0] rs1, rs2, rd;

  inst_class_dec u_dec (
    .inst      (bus.inst),
    .uses_rs1  (uses_rs1),
    .uses_rs2  (uses_rs2),
    .writes_rd (writes_rd),
    .is_load   (is_load),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd)
  );

  slot_t            ex_s, mem_s, wb_s;
  fwd_sel_e         fwd_a_q, fwd_b_q;
  ctrl_state_e      state_q;
  logic [CNT_W-1:0] stall_q, flush_q;

  ctrl_state_e action;
  fwd_sel_e    sel_a, sel_b;
  slot_t       issue;
  logic        hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b, load_use;
  logic        unused_slots;

  // WB hazards resolve through regfile write-first; wb_s is kept only for visibility.
  assign unused_slots = ^{wb_s, mem_s.is_load};

  always_comb begin
    hit_ex_a  = slot_hit(ex_s, rs1, uses_rs1);
    hit_ex_b  = slot_hit(ex_s, rs2, uses_rs2);
    hit_mem_a = slot_hit(mem_s, rs1, uses_rs1);
    hit_mem_b = slot_hit(mem_s, rs2, uses_rs2);
    load_use  = bus.id_valid && ex_s.is_load && (hit_ex_a || hit_ex_b);

    if (bus.mem_stall)        action = StFreeze;
    else if (bus.ex_redirect) action = StFlush;
    else if (load_use)        action = StStall;
    else                      action = StRun;

    sel_a = FwdRf;
    sel_b = FwdRf;
    if (bus.id_valid) begin
      if (hit_ex_a)       sel_a = FwdExMem;
      else if (hit_mem_a) sel_a = FwdMemWb;
      if (hit_ex_b)       sel_b = FwdExMem;
      else if (hit_mem_b) sel_b = FwdMemWb;
    end

    issue.valid   = bus.id_valid && writes_rd;
    issue.rd      = rd;
    issue.is_load = bus.id_valid && is_load;
  end

  always_comb begin
    bus.pc_en        = 1'b0;
    bus.if_id_en     = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_bubble = 1'b0;
    if (rst) begin
      bus.if_id_flush  = 1'b1;
      bus.id_ex_bubble = 1'b1;
    end else begin
      unique case (action)
        StRun: begin
          bus.pc_en        = 1'b1;
          bus.if_id_en     = 1'b1;
          bus.id_ex_bubble = !bus.id_valid;
        end
        StStall: bus.id_ex_bubble = 1'b1;
        StFlush: begin
          bus.pc_en        = 1'b1;
          bus.if_id_en     = 1'b1;
          bus.if_id_flush  = 1'b1;
          bus.id_ex_bubble = 1'b1;
        end
        StFreeze: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_s    <= '0;
      mem_s   <= '0;
      wb_s    <= '0;
      fwd_a_q <= FwdRf;
      fwd_b_q <= FwdRf;
      state_q <= StRun;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= action;
      if (action != StFreeze) begin
        wb_s  <= mem_s;
        mem_s <= ex_s;
        if (action == StRun) begin
          ex_s    <= issue;
          fwd_a_q <= sel_a;
          fwd_b_q <= sel_b;
        end else begin
          ex_s    <= '0;
          fwd_a_q <= FwdRf;
          fwd_b_q <= FwdRf;
        end
      end
      if (action == StStall && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (action == StFlush && flush_q != '1) flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.fwd_a_sel  = fwd_a_q;
  assign bus.fwd_b_sel  = fwd_b_q;
  assign bus.ctrl_state = state_q;
  assign bus.stall_cnt  = stall_q;
  assign bus.flush_cnt  = flush_q;

endmodule
